time_display: RTL
=================

# time_display

Display-side consumer of the alarm controller's 15-bit countdown value: takes the remaining time in hundredths of a second, converts it to five BCD digits with a multi-cycle shift-add-3 engine, and drives a multiplexed, active-low 5-digit 7-segment display. Sits between the controller's `nextTime` output and the board display pins. Conversion and scanning run concurrently. The displayed digits change only when a full conversion completes, so the display never shows a partially converted value.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays active; legal range ≥ 2.
- `clk` input 1: system clock; all state on rising edge.
- `reset_n` input 1: reset is asynchronous and active-low.
- `time_in` input 15: remaining time in hundredths (0–32767), synchronous to `clk`.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `dp` output 1: decimal point, active-low, registered.
- `an` output 5: digit enables, active-low, one-hot-low, registered; bit 0 is the hundredths digit.
- `busy` output 1: high while a conversion is in progress.

## Operation
- Registers:
  - `last_val[14:0]`, resets to 0.
  - `digits[19:0]` display register, 5 nibbles, resets to 0.
  - Converter shift register {bcd[19:0], bin[14:0]}.
  - 4-bit iteration counter.
- Converter FSM states: IDLE, SHIFT, DONE. Reset → IDLE.
- IDLE:
  - If `time_in != last_val`: load bin ← `time_in`, bcd ← 0, `last_val` ← `time_in`, count ← 0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Add 3 to every bcd nibble ≥ 5.
  - Then shift the combined {bcd,bin} left 1.
  - count++. After the iteration with count == 14 (15 iterations total), go to DONE.
- DONE: `digits` ← bcd, all 5 nibbles in the same edge; go to IDLE.
- `time_in` changes while in SHIFT or DONE are ignored. The first IDLE cycle afterwards compares against `last_val` and restarts if the value differs, so the final value always gets displayed.
- `busy` = (state != IDLE).
- Scanner:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count it wraps to 0 and advances digit index 0→1→2→3→4→0.
- Each cycle the output registers load:
  - `an` ← all ones except bit[idx] = 0.
  - `seg` ← 7-seg decode of `digits[idx]`. Nibble codes 10–15 cannot occur; decode them as blank (7'h7F).
  - `dp` ← 0 when idx == 2 (ones-of-seconds digit, giving format SSS.hh); 1 otherwise.
- Reset mid-conversion: conversion is abandoned; FSM, `last_val`, `digits`, prescaler and index all return to reset values.

## Timing
- Reset values:
  - `seg` = 7'h7F, `dp` = 1, `an` = 5'h1F, `busy` = 0.
  - State IDLE, idx 0, prescaler 0.
- First valid scan output appears on the first clock edge after `reset_n` deasserts.
- Conversion latency:
  - Edge E0 (IDLE, mismatch) captures the value.
  - Edges E1–E15 perform the 15 shifts.
  - Edge E16 (DONE) updates `digits`.
  - `busy` is high from after E0 through E16, i.e. 16 cycles.
  - The new digit reaches `seg` on the first scan register update after E16 in which that digit is selected (≤ 1 cycle if selected).
- Digit dwell: exactly SCAN_DIV cycles per digit; full frame = 5·SCAN_DIV cycles.
- Back-to-back changes: minimum spacing between captures is 17 cycles.

## Configuration
- `TIME_DISPLAY_BLANK_EN`, defined: leading-zero blanking.
  - Digit 4 is blanked (`seg` = 7'h7F) when its nibble is 0.
  - Digit 3 is blanked when digits 4 and 3 are both 0.
  - Digits 2..0 are always shown, so 0 displays as "0.00".
  - `an` is unchanged; the blanked digit is still scanned.
- Undefined: all five digits are always shown, so 0 displays as "000.00".

## Test plan
- Reset, hold `time_in` = 0 → no conversion (`busy` stays 0); with SCAN_DIV = 4, `an` cycles 11110, 11101, 11011, 10111, 01111, each for 4 cycles; `seg` = 7'h40 ("0") on every digit (digits 3, 4 blank with the macro); `dp` = 0 only while `an` = 11011.
- `time_in` = 12345 → `busy` high for 16 cycles; `digits` = 0x12345 at edge 16; each digit's `seg` matches the 1/2/3/4/5 decode.
- `time_in` = 32767 → `digits` = 0x32767 after 16 cycles; `time_in` = 0 → `digits` = 0x00000.
- `time_in` = 100, then 200 at cycle 5 of conversion → `digits` = 0x00100 at edge 16, second conversion starts at edge 17, `digits` = 0x00200 at edge 33.
- Assert `reset_n` low at cycle 7 of a conversion of 999 → all outputs return to reset values immediately; after release, `time_in` = 999 mismatches `last_val` = 0 and `digits` = 0x00999 16 cycles after capture.
- With `TIME_DISPLAY_BLANK_EN`, `time_in` = 5 → digits 4, 3 show `seg` = 7'h7F; digit 2 shows "0" with `dp` = 0; digit 1 shows "0"; digit 0 shows "5".

Source files
------------

// File: rtl/time_display.sv
// time_display
// Converts the 15-bit countdown (hundredths of a second) to five BCD digits
// with a multi-cycle shift-add-3 engine, then scans them onto a multiplexed
// active-low 5-digit 7-segment display (format SSS.hh).
//
// Optional feature macro: TIME_DISPLAY_BLANK_EN (leading-zero blanking of
// digits 4 and 3). Undefined: all five digits always shown.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   time_in  in   remaining time in hundredths (0..32767)
//   seg      out  segments {g,f,e,d,c,b,a}, active-low, registered
//   dp       out  decimal point, active-low, registered
//   an       out  digit enables, one-hot-low, bit 0 = hundredths digit
//   busy     out  high while a conversion is in progress
//
// Converter FSM
//   state    | meaning
//   ST_IDLE  | waiting for time_in to differ from last captured value
//   ST_SHIFT | one add-3/shift iteration per cycle, 15 total
//   ST_DONE  | copy finished BCD into the display register
module time_display #(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [14:0] time_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [4:0]  an,
   output logic        busy
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PSC_TC = PW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t        state_q, state_d;
   logic [14:0]   last_val_q, last_val_d;
   logic [19:0]   digits_q, digits_d;
   logic [19:0]   bcd_q, bcd_d;
   logic [14:0]   bin_q, bin_d;
   logic [3:0]    count_q, count_d;
   logic [19:0]   bcd_adj;

   logic [PW-1:0] psc_q, psc_d;
   logic [2:0]    idx_q, idx_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [4:0]    an_q, an_d;
   logic [3:0]    nib;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      last_val_d = last_val_q;
      digits_d   = digits_q;
      bcd_d      = bcd_q;
      bin_d      = bin_q;
      count_d    = count_q;
      case (state_q)
         ST_IDLE: begin
            if (time_in != last_val_q) begin
               bin_d      = time_in;
               bcd_d      = '0;
               last_val_d = time_in;
               count_d    = '0;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            count_d        = count_q + 4'd1;
            if (count_q == 4'd14) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            digits_d = bcd_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);

   always_comb begin
      psc_d = psc_q + 1'b1;
      idx_d = idx_q;
      if (psc_q == PSC_TC) begin
         psc_d = '0;
         idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end
   end

   always_comb begin
      case (idx_q)
         3'd0:    nib = digits_q[3:0];
         3'd1:    nib = digits_q[7:4];
         3'd2:    nib = digits_q[11:8];
         3'd3:    nib = digits_q[15:12];
         default: nib = digits_q[19:16];
      endcase
      case (nib)
         4'd0:    seg_d = 7'h40;
         4'd1:    seg_d = 7'h79;
         4'd2:    seg_d = 7'h24;
         4'd3:    seg_d = 7'h30;
         4'd4:    seg_d = 7'h19;
         4'd5:    seg_d = 7'h12;
         4'd6:    seg_d = 7'h02;
         4'd7:    seg_d = 7'h78;
         4'd8:    seg_d = 7'h00;
         4'd9:    seg_d = 7'h10;
         default: seg_d = 7'h7F;
      endcase
`ifdef TIME_DISPLAY_BLANK_EN
      if ((idx_q == 3'd4) && (digits_q[19:16] == 4'd0)) seg_d = 7'h7F;
      if ((idx_q == 3'd3) && (digits_q[19:12] == 8'd0)) seg_d = 7'h7F;
`endif
      an_d = ~(5'b00001 << idx_q);
      dp_d = (idx_q != 3'd2);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         last_val_q <= '0;
         digits_q   <= '0;
         bcd_q      <= '0;
         bin_q      <= '0;
         count_q    <= '0;
         psc_q      <= '0;
         idx_q      <= '0;
         seg_q      <= 7'h7F;
         dp_q       <= 1'b1;
         an_q       <= 5'h1F;
      end else begin
         state_q    <= state_d;
         last_val_q <= last_val_d;
         digits_q   <= digits_d;
         bcd_q      <= bcd_d;
         bin_q      <= bin_d;
         count_q    <= count_d;
         psc_q      <= psc_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         an_q       <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;
   assign an  = an_q;

endmodule
